// File: rtl/match_ctl.sv
// rtl/match_ctl.sv - Pong rally/match sequencer: miss detection, scoring, serve gating (optional pause via MATCH_CTL_PAUSE_EN)
module match_ctl #(
  parameter int X_LEFT_EDGE  = 0,
  parameter int X_RIGHT_EDGE = 1024,
  parameter int SERVE_DELAY  = 65_000_000,
  parameter int WIN_POINTS   = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
`ifdef MATCH_CTL_PAUSE_EN
  input  logic        pause,
`endif
  input  logic [10:0] ball_xpos,
  output logic        ball_run,
  output logic        ball_restart,
  output logic        serve_dir,
  output logic [6:0]  points_first_player,
  output logic [6:0]  points_second_player,
  output logic        game_over,
  output logic        winner,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    IDLE       = 3'b000,
    SERVE_WAIT = 3'b001,
    PLAY       = 3'b010,
    POINT      = 3'b011,
    GAME_OVER  = 3'b100,
    PAUSED     = 3'b101
  } state_t;

  localparam int              CW     = $clog2(SERVE_DELAY);
  localparam logic [CW-1:0]   RELOAD = CW'(SERVE_DELAY - 1);
  localparam logic [10:0]     XL     = 11'(X_LEFT_EDGE);
  localparam logic [10:0]     XR     = 11'(X_RIGHT_EDGE);
  localparam logic [6:0]      WIN    = 7'(WIN_POINTS);

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [6:0]    p1_q, p1_n, p2_q, p2_n;
  logic          dir_q, dir_n, win_q, win_n, restart_n;
  logic          run_q, over_q, restart_q;
  logic          miss_left, miss_right;

  function automatic logic [6:0] sat_inc(input logic [6:0] v);
    return (v == 7'h7f) ? v : v + 7'd1;
  endfunction

  assign miss_left  = (ball_xpos <= XL);
  assign miss_right = (ball_xpos >= XR);

  // Next-state, counter and score logic; outputs are derived from these and registered.
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    p1_n      = p1_q;
    p2_n      = p2_q;
    dir_n     = dir_q;
    win_n     = win_q;
    restart_n = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          p1_n      = 7'd0;
          p2_n      = 7'd0;
          restart_n = 1'b1;
          cnt_n     = RELOAD;
          state_n   = SERVE_WAIT;
        end
      end
      SERVE_WAIT: begin
        if (cnt_q == '0) state_n = PLAY;
        else             cnt_n   = cnt_q - 1'b1;
      end
      PLAY: begin
`ifdef MATCH_CTL_PAUSE_EN
        if (pause) state_n = PAUSED;
        else
`endif
        if (miss_left) begin
          // Serve goes toward the player who just missed.
          p2_n      = sat_inc(p2_q);
          dir_n     = 1'b0;
          restart_n = 1'b1;
          state_n   = POINT;
        end else if (miss_right) begin
          p1_n      = sat_inc(p1_q);
          dir_n     = 1'b1;
          restart_n = 1'b1;
          state_n   = POINT;
        end
      end
      POINT: begin
        if ((p1_q == WIN) || (p2_q == WIN)) begin
          win_n   = (p2_q == WIN);
          state_n = GAME_OVER;
        end else begin
          cnt_n   = RELOAD;
          state_n = SERVE_WAIT;
        end
      end
      GAME_OVER: begin
        if (start) begin
          p1_n      = 7'd0;
          p2_n      = 7'd0;
          dir_n     = 1'b0;
          restart_n = 1'b1;
          cnt_n     = RELOAD;
          state_n   = SERVE_WAIT;
        end
      end
`ifdef MATCH_CTL_PAUSE_EN
      PAUSED: begin
        if (pause) state_n = PLAY;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      p1_q      <= 7'd0;
      p2_q      <= 7'd0;
      dir_q     <= 1'b0;
      win_q     <= 1'b0;
      restart_q <= 1'b0;
      run_q     <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      p1_q      <= p1_n;
      p2_q      <= p2_n;
      dir_q     <= dir_n;
      win_q     <= win_n;
      restart_q <= restart_n;
      run_q     <= (state_n == PLAY);
      over_q    <= (state_n == GAME_OVER);
    end
  end

  assign ball_run             = run_q;
  assign ball_restart         = restart_q;
  assign serve_dir            = dir_q;
  assign points_first_player  = p1_q;
  assign points_second_player = p2_q;
  assign game_over            = over_q;
  assign winner               = win_q;
  assign state_o              = state_q;

endmodule

// File: tb/tb_match_ctl.sv
// tb/tb_match_ctl.sv - directed self-checking bench for match_ctl
module tb_match_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] ball_xpos;
  logic        ball_run, ball_restart, serve_dir, game_over, winner;
  logic [6:0]  p1, p2;
  logic [2:0]  state_o;
`ifdef MATCH_CTL_PAUSE_EN
  logic        pause = 1'b0;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  match_ctl #(
    .X_LEFT_EDGE (0),
    .X_RIGHT_EDGE(1024),
    .SERVE_DELAY (4),
    .WIN_POINTS  (3)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
`ifdef MATCH_CTL_PAUSE_EN
    .pause               (pause),
`endif
    .ball_xpos           (ball_xpos),
    .ball_run            (ball_run),
    .ball_restart        (ball_restart),
    .serve_dir           (serve_dir),
    .points_first_player (p1),
    .points_second_player(p2),
    .game_over           (game_over),
    .winner              (winner),
    .state_o             (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_play;
    for (int i = 0; i < 40; i++) begin
      if (state_o == 3'b010) break;
      tick;
    end
    check("wait_play", 32'(state_o), 2);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; ball_xpos = 11'd512;
    repeat (3) tick;
    check("rst_state",   32'(state_o), 0);
    check("rst_p1",      32'(p1), 0);
    check("rst_p2",      32'(p2), 0);
    check("rst_run",     32'(ball_run), 0);
    check("rst_restart", 32'(ball_restart), 0);
    check("rst_dir",     32'(serve_dir), 0);
    check("rst_over",    32'(game_over), 0);
    check("rst_winner",  32'(winner), 0);
    rst = 1'b1;
    tick;
    check("idle_hold", 32'(state_o), 0);

    // Start: serve wait held exactly 4 cycles, start ignored inside it.
    start = 1'b1; tick; start = 1'b0;
    check("t1_sw1_state",   32'(state_o), 1);
    check("t1_sw1_restart", 32'(ball_restart), 1);
    check("t1_sw1_run",     32'(ball_run), 0);
    tick;
    check("t1_sw2_state",   32'(state_o), 1);
    check("t1_sw2_restart", 32'(ball_restart), 0);
    start = 1'b1; tick; start = 1'b0;
    check("t1_sw3_state",   32'(state_o), 1);
    check("t1_sw3_restart", 32'(ball_restart), 0);
    tick;
    check("t1_sw4_state",   32'(state_o), 1);
    tick;
    check("t1_play_state",  32'(state_o), 2);
    check("t1_play_run",    32'(ball_run), 1);
    start = 1'b1; tick; start = 1'b0;
    check("play_start_ign", 32'(state_o), 2);

    // Left miss credits player two once, even with xpos held at the edge.
    ball_xpos = 11'd0; tick;
    check("t2_p2",      32'(p2), 1);
    check("t2_p1",      32'(p1), 0);
    check("t2_restart", 32'(ball_restart), 1);
    check("t2_dir",     32'(serve_dir), 0);
    check("t2_state",   32'(state_o), 3);
    check("t2_run",     32'(ball_run), 0);
    tick;
    check("t2_sw_state", 32'(state_o), 1);
    check("t2_sw_rst",   32'(ball_restart), 0);
    repeat (3) tick;
    check("t2_sw_p2",    32'(p2), 1);
    check("t2_sw_state4", 32'(state_o), 1);
    ball_xpos = 11'd512; tick;
    check("t2_play",     32'(state_o), 2);
    check("t2_play_p2",  32'(p2), 1);

    // Right miss credits player one and serves right.
    ball_xpos = 11'd1024; tick;
    check("t3_p1",    32'(p1), 1);
    check("t3_dir",   32'(serve_dir), 1);
    check("t3_state", 32'(state_o), 3);
    ball_xpos = 11'd512;
    wait_play;

    // Player one reaches 3 and wins.
    ball_xpos = 11'd2000; tick;
    check("t4_p1_2", 32'(p1), 2);
    ball_xpos = 11'd512;
    wait_play;
    ball_xpos = 11'd1024; tick;
    check("t4_p1_3", 32'(p1), 3);
    ball_xpos = 11'd512; tick;
    check("t4_state",  32'(state_o), 4);
    check("t4_over",   32'(game_over), 1);
    check("t4_winner", 32'(winner), 0);
    check("t4_run",    32'(ball_run), 0);
    check("t4_p2",     32'(p2), 1);
    tick;
    check("t4_hold",   32'(state_o), 4);
    check("t4_hold_p1", 32'(p1), 3);
    start = 1'b1; tick; start = 1'b0;
    check("t4_rs_state",   32'(state_o), 1);
    check("t4_rs_p1",      32'(p1), 0);
    check("t4_rs_p2",      32'(p2), 0);
    check("t4_rs_over",    32'(game_over), 0);
    check("t4_rs_restart", 32'(ball_restart), 1);
    check("t4_rs_dir",     32'(serve_dir), 0);

    // Near-edge positions are not misses; then player two wins.
    wait_play;
    ball_xpos = 11'd1; tick;
    check("near_left",  32'(state_o), 2);
    ball_xpos = 11'd1023; tick;
    check("near_right", 32'(state_o), 2);
    for (int i = 1; i <= 3; i++) begin
      wait_play;
      ball_xpos = 11'd0; tick;
      check("p2_run", 32'(p2), 32'(i));
      ball_xpos = 11'd512;
    end
    tick;
    check("p2_win_state",  32'(state_o), 4);
    check("p2_win_winner", 32'(winner), 1);
    check("p2_win_p1",     32'(p1), 0);
    start = 1'b1; tick; start = 1'b0;
    wait_play;

    // Asynchronous reset mid-PLAY, between clock edges.
    ball_xpos = 11'd1024; tick;
    ball_xpos = 11'd512;
    wait_play;
    check("t5_pre_p1", 32'(p1), 1);
    #3 rst = 1'b0;
    #1;
    check("t5_state", 32'(state_o), 0);
    check("t5_run",   32'(ball_run), 0);
    check("t5_p1",    32'(p1), 0);
    check("t5_dir",   32'(serve_dir), 0);
    tick; tick;
    rst = 1'b1;
    tick;
    check("t5_idle", 32'(state_o), 0);
    start = 1'b1; tick; start = 1'b0;
    check("t5_start_state",   32'(state_o), 1);
    check("t5_start_restart", 32'(ball_restart), 1);

`ifdef MATCH_CTL_PAUSE_EN
    wait_play;
    pause = 1'b1; tick; pause = 1'b0;
    check("t6_paused", 32'(state_o), 5);
    check("t6_run",    32'(ball_run), 0);
    ball_xpos = 11'd0; tick;
    check("t6_nomiss", 32'(state_o), 5);
    check("t6_p2",     32'(p2), 0);
    start = 1'b1; tick; start = 1'b0;
    check("t6_start_ign", 32'(state_o), 5);
    pause = 1'b1; tick; pause = 1'b0;
    check("t6_resume", 32'(state_o), 2);
    check("t6_resume_run", 32'(ball_run), 1);
    tick;
    check("t6_miss_state", 32'(state_o), 3);
    check("t6_miss_p2",    32'(p2), 1);
    ball_xpos = 11'd512;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/match_ctl.md
Name: match_ctl

Overview:
- Top-level rally/match sequencer for the Pong datapath.
- Watches the ball x position produced by ball_ctl and detects misses at the left and right field edges.
- Keeps both players' scores, which feed ball_ctl's points inputs, and gates ball motion through serve delays.
- Declares the game over at a target score; the next start press restarts the match.

Parameters:
- X_LEFT_EDGE, 0: ball_xpos at or below this value is a miss by player one; player two scores.
- X_RIGHT_EDGE, 1024: ball_xpos at or above this value is a miss by player two; player one scores.
- SERVE_DELAY, 65_000_000: cycles the ball is held centred before each serve. Must be >= 2.
- WIN_POINTS, 11: score that ends the match. Range 1..127.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset. Asserted (0) clears all state immediately.
- start  in  1  single-cycle start pulse (debounced button).
- ball_xpos  in  11  current ball x position from ball_ctl.
- ball_run  out  1  1 = ball_ctl may move the ball; 0 = ball frozen.
- ball_restart  out  1  one-cycle pulse: ball_ctl recentres the ball.
- serve_dir  out  1  0 = serve toward player one (left); 1 = toward player two (right).
- points_first_player  out  7  player one score.
- points_second_player  out  7  player two score.
- game_over  out  1  high while in GAME_OVER.
- winner  out  1  0 = player one, 1 = player two. Valid while game_over = 1.
- state_o  out  3  current FSM state, for debug and the bench.

Behaviour:
- Reset (rst = 0): state IDLE, both scores 0, ball_run 0, ball_restart 0, serve_dir 0, game_over 0, winner 0, serve counter 0.
- All outputs are registered; there is no combinational path from any input to any output.
- FSM encoding: IDLE = 000, SERVE_WAIT = 001, PLAY = 010, POINT = 011, GAME_OVER = 100, PAUSED = 101 (PAUSED only exists with the optional feature).
- IDLE:
  - ball_run = 0.
  - On start: clear scores, pulse ball_restart for 1 cycle, load the serve counter with SERVE_DELAY-1, go to SERVE_WAIT.
- SERVE_WAIT:
  - ball_run = 0; ball_xpos is ignored.
  - Counter decrements once per cycle.
  - At 0: go to PLAY. ball_run rises on the first PLAY cycle, so the state is held exactly SERVE_DELAY cycles.
- PLAY:
  - ball_run = 1.
  - ball_xpos <= X_LEFT_EDGE: player two scores, serve_dir <= 0 (serve toward the loser), go to POINT.
  - ball_xpos >= X_RIGHT_EDGE: player one scores, serve_dir <= 1, go to POINT.
  - If both conditions hold in the same cycle, the left-edge condition wins.
- POINT (exactly 1 cycle):
  - ball_run = 0; scores increment here, saturating at 127; ball_restart pulses.
  - If the new score equals WIN_POINTS: set winner, go to GAME_OVER.
  - Otherwise: reload the counter, go to SERVE_WAIT.
  - Exactly one point is credited per miss, because xpos is ignored until the next PLAY.
- GAME_OVER:
  - ball_run = 0, game_over = 1; scores held for display.
  - On start: clear scores, clear game_over, pulse ball_restart, serve_dir <= 0, go to SERVE_WAIT.
- start is ignored in SERVE_WAIT, PLAY and POINT.
- Reset asserted in any state aborts immediately to the reset values. After release, the next start begins a fresh match.
- Latency: miss visible in PLAY -> score updated and ball_restart high 1 cycle later (in POINT).

Optional Feature:
- Macro: MATCH_CTL_PAUSE_EN.
- Defined:
  - Adds input pause (1 bit, single-cycle pulse) and state PAUSED.
  - pause in PLAY -> PAUSED with ball_run = 0; scores frozen; misses not checked.
  - pause in PAUSED -> back to PLAY.
  - start in PAUSED is ignored.
  - pause in any other state is ignored.
- Undefined: no pause port, no PAUSED state; encoding 101 is unreachable.

Test Plan:
1. Reset, then start, with SERVE_DELAY = 4 -> ball_restart high 1 cycle; state_o = 001 for 4 cycles; then 010 with ball_run = 1.
2. In PLAY, drive ball_xpos = 0 -> next cycle points_second_player = 1, ball_restart = 1, serve_dir = 0, state_o = 011. Holding xpos = 0 through SERVE_WAIT adds no further points.
3. In PLAY, drive ball_xpos = 1024 -> points_first_player increments by 1; serve_dir = 1.
4. WIN_POINTS = 3; player one scores 3 times -> game_over = 1, winner = 0, state_o = 100, ball_run = 0. Then start -> both scores 0, state_o = 001.
5. Assert rst = 0 mid-PLAY, asynchronously between clock edges -> outputs go to reset values without waiting for a clock edge; state_o = 000. start pulses in SERVE_WAIT have no effect.
6. With MATCH_CTL_PAUSE_EN: pause in PLAY -> state_o = 101, ball_run = 0; ball_xpos = 0 gives no point; second pause -> back to PLAY, and the miss is then credited.
